// File: rtl/core_featuremap_conv2d_0_packer.sv
// Packs three DWIDTH-bit channel words (ch0, ch1, ch2) into one pixel word for the conv2d_0 filter FIFO.
// It stalls on a full FIFO only while a finished pixel is still waiting, and counts pixels per frame.
module core_featuremap_conv2d_0_packer #(
  parameter int DWIDTH     = 32,
  parameter int NUM_PIXELS = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_clear,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DWIDTH*3-1:0]   ff_wdata,
  output logic                  ff_wrreq,
  input  logic                  ff_full,
  output logic [CNT_W-1:0]      pixel_count,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    S_C0 = 2'd0,
    S_C1 = 2'd1,
    S_C2 = 2'd2
  } ch_sel_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ch_sel_t                ch_sel_r, ch_sel_nxt_s;
  logic                   pend_r, pend_nxt_s;
  logic [DWIDTH-1:0]      ch0_r, ch0_nxt_s;
  logic [DWIDTH-1:0]      ch1_r, ch1_nxt_s;
  logic [DWIDTH*3-1:0]    wdata_r, wdata_nxt_s;
  logic [CNT_W-1:0]       count_r, count_nxt_s;
  logic                   frame_done_r, frame_done_nxt_s;
  logic                   beat_s;
  logic                   write_s;

  // Handshake terms: input is only blocked when a finished pixel cannot leave.
  always_comb begin
    in_ready = ~pend_r | ~ff_full;
    write_s  = pend_r & ~ff_full;
    beat_s   = in_valid & in_ready;
    ff_wrreq = write_s;
  end

  // Next-state logic for the channel FSM, pixel staging and frame counter.
  always_comb begin
    ch_sel_nxt_s     = ch_sel_r;
    pend_nxt_s       = pend_r;
    ch0_nxt_s        = ch0_r;
    ch1_nxt_s        = ch1_r;
    wdata_nxt_s      = wdata_r;
    count_nxt_s      = count_r;
    frame_done_nxt_s = 1'b0;
    if (soft_clear) begin
      ch_sel_nxt_s     = S_C0;
      pend_nxt_s       = 1'b0;
      count_nxt_s      = '0;
      frame_done_nxt_s = 1'b0;
    end else begin
      if (write_s) begin
        pend_nxt_s = 1'b0;
        if (count_r == LAST_PIX) begin
          count_nxt_s      = '0;
          frame_done_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r + CNT_ONE;
        end
      end else begin
        frame_done_nxt_s = 1'b0;
      end
      // A ch2 beat reloads the staging word, overriding the write's clear of pend.
      if (beat_s) begin
        case (ch_sel_r)
          S_C0: begin
            ch0_nxt_s    = in_data;
            ch_sel_nxt_s = S_C1;
          end
          S_C1: begin
            ch1_nxt_s    = in_data;
            ch_sel_nxt_s = S_C2;
          end
          S_C2: begin
            wdata_nxt_s  = {in_data, ch1_r, ch0_r};
            pend_nxt_s   = 1'b1;
            ch_sel_nxt_s = S_C0;
          end
          default: begin
            ch_sel_nxt_s = S_C0;
          end
        endcase
      end else begin
        ch_sel_nxt_s = ch_sel_nxt_s;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch_sel_r     <= S_C0;
      pend_r       <= 1'b0;
      ch0_r        <= '0;
      ch1_r        <= '0;
      wdata_r      <= '0;
      count_r      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      ch_sel_r     <= ch_sel_nxt_s;
      pend_r       <= pend_nxt_s;
      ch0_r        <= ch0_nxt_s;
      ch1_r        <= ch1_nxt_s;
      wdata_r      <= wdata_nxt_s;
      count_r      <= count_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign ff_wdata    = wdata_r;
  assign pixel_count = count_r;
  assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_core_featuremap_conv2d_0_packer.sv
// Directed bench for the conv2d_0 packer, built with a 4-pixel frame.
// Expected pixels go into a scoreboard queue when their ch2 beat is driven and are popped on each FIFO write.
module tb_core_featuremap_conv2d_0_packer;

  localparam int DWIDTH = 32;
  localparam int NP     = 4;
  localparam int CNT_W  = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 soft_clear;
  logic [DWIDTH-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DWIDTH*3-1:0]  ff_wdata;
  logic                 ff_wrreq;
  logic                 ff_full;
  logic [CNT_W-1:0]     pixel_count;
  logic                 frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_seen = 0;
  int wr_seen = 0;

  // Reference state
  logic                 m_pend;
  int                   m_sel;
  logic [DWIDTH-1:0]    m_ch0, m_ch1;
  int                   m_count;
  logic                 m_fd;
  logic [DWIDTH*3-1:0]  sb_q[$];
  logic [DWIDTH*3-1:0]  exp_pix;

  core_featuremap_conv2d_0_packer #(
    .DWIDTH(DWIDTH), .NUM_PIXELS(NP), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .soft_clear(soft_clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ff_wdata(ff_wdata), .ff_wrreq(ff_wrreq), .ff_full(ff_full),
    .pixel_count(pixel_count), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_sel   = 0;
    m_ch0   = '0;
    m_ch1   = '0;
    m_count = 0;
    m_fd    = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: drive at negedge, check combinational/registered outputs, then advance the model.
  task automatic cycle(input logic v, input logic [DWIDTH-1:0] d, input logic full, input logic clr);
    logic beat, wr;
    in_valid   = v;
    in_data    = d;
    ff_full    = full;
    soft_clear = clr;
    #1;
    beat = v & (~m_pend | ~full);
    wr   = m_pend & ~full;
    check("in_ready", {95'd0, in_ready}, {95'd0, ~m_pend | ~full});
    check("ff_wrreq", {95'd0, ff_wrreq}, {95'd0, wr});
    check("pixel_count", {80'd0, pixel_count}, {80'd0, 16'(m_count)});
    check("frame_done", {95'd0, frame_done}, {95'd0, m_fd});
    if (frame_done === 1'b1) fd_seen++;
    if (ff_wrreq === 1'b1) wr_seen++;
    if (m_pend) begin
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 96'd0, 96'd1);
      end else begin
        check("ff_wdata", ff_wdata, sb_q[0]);
        if (wr) void'(sb_q.pop_front());
      end
    end
    @(posedge clock);
    if (clr) begin
      m_sel  = 0;
      m_pend = 1'b0;
      m_count = 0;
      m_fd   = 1'b0;
      sb_q.delete();
    end else begin
      m_fd = wr && (m_count == NP - 1);
      if (wr) m_count = (m_count == NP - 1) ? 0 : m_count + 1;
      if (beat && m_sel == 2) begin
        sb_q.push_back({d, m_ch1, m_ch0});
        m_pend = 1'b1;
        m_sel  = 0;
      end else begin
        if (wr) m_pend = 1'b0;
        if (beat && m_sel == 0) begin m_ch0 = d; m_sel = 1; end
        else if (beat && m_sel == 1) begin m_ch1 = d; m_sel = 2; end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    reset      = 1'b0;
    soft_clear = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    ff_full    = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    // Reset state
    check("rst_wrreq", {95'd0, ff_wrreq}, 96'd0);
    check("rst_in_ready", {95'd0, in_ready}, 96'd1);
    check("rst_wdata", ff_wdata, 96'd0);
    check("rst_count", {80'd0, pixel_count}, 96'd0);
    check("rst_frame_done", {95'd0, frame_done}, 96'd0);
    reset = 1'b1;
    @(negedge clock);

    // 1: first pixel A,B,C
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    check("t1_wrreq", {95'd0, ff_wrreq}, 96'd1);
    check("t1_wdata", ff_wdata, 96'h00000033_00000022_00000011);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_count", {80'd0, pixel_count}, 96'd1);

    // 2: 30 continuous beats
    wr_seen = 0;
    for (int i = 0; i < 30; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("t2_writes", 96'(wr_seen), 96'd10);
    check("t2_queue_drained", 96'(sb_q.size()), 96'd0);

    // 3: backpressure with a pending pixel
    cycle(1'b1, 32'hA0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA1, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 1'b0, 1'b0);
    wr_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hDEAD0000 + 32'(i), 1'b1, 1'b0);
    check("t3_held_wdata", ff_wdata, 96'h000000A2_000000A1_000000A0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_single_write", 96'(wr_seen), 96'd1);

    // 4: one full frame from a cleared counter
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    fd_seen = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_frame_pulses", 96'(fd_seen), 96'd1);
    check("t4_count_wrapped", {80'd0, pixel_count}, 96'd0);

    // 5: soft clear drops a partial pixel
    cycle(1'b1, 32'hBAD0, 1'b0, 1'b0);
    cycle(1'b1, 32'hBAD1, 1'b0, 1'b0);
    cycle(1'b1, 32'hBAD2, 1'b0, 1'b1);
    cycle(1'b1, 32'hC0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC1, 1'b0, 1'b0);
    cycle(1'b1, 32'hC2, 1'b0, 1'b0);
    check("t5_wdata", ff_wdata, 96'h000000C2_000000C1_000000C0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_count", {80'd0, pixel_count}, 96'd1);

    // 6: asynchronous reset while a pixel is stuck behind a full FIFO
    cycle(1'b1, 32'hE0, 1'b1, 1'b0);
    cycle(1'b1, 32'hE1, 1'b1, 1'b0);
    cycle(1'b1, 32'hE2, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_blocked", {95'd0, in_ready}, 96'd0);
    #2 reset = 1'b0;
    #1;
    check("t6_wrreq", {95'd0, ff_wrreq}, 96'd0);
    check("t6_in_ready", {95'd0, in_ready}, 96'd1);
    check("t6_wdata", ff_wdata, 96'd0);
    check("t6_count", {80'd0, pixel_count}, 96'd0);
    check("t6_frame_done", {95'd0, frame_done}, 96'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    ff_full = 1'b0;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
